// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix-multiply engine: streams A columns / B rows
// through a skewed PE grid, then drains C one row per handshake.
module systolic_mm_engine #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int K_MAX = 256,
  parameter int ACC_W = 2*DW + $clog2(K_MAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DW-1:0]            a_data,
  input  logic [N*DW-1:0]            b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*ACC_W-1:0]         out_row,
  output logic [$clog2(N)-1:0]       out_row_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int FW = $clog2(2*N);
  localparam int RW = $clog2(N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t          state;
  logic [KW-1:0]   k_lat;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [KW-1:0]   k_clamped;
  logic            accept;
  logic            clear_acc;

  assign k_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  // in_ready is only ever high in LOAD, so this is the complete beat-accept condition.
  assign accept    = in_ready & in_valid;
  assign clear_acc = (state == S_IDLE) & start;

  // Control FSM with registered handshake/status outputs.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      k_lat       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            k_lat     <= k_clamped;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b1;
            if (k_clamped == '0) begin
              state <= S_FLUSH;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_lat - KW'(1)) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Covers the skew depth plus the diagonal walk to PE(N-1,N-1).
          if (flush_cnt == FLUSH_LAST) begin
            state       <= S_DRAIN;
            out_valid   <= 1'b1;
            out_row_idx <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == ROW_LAST) begin
              state       <= S_IDLE;
              out_valid   <= 1'b0;
              out_row_idx <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              out_row_idx <= out_row_idx + RW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Input skew: lane i passes through i+1 registers, the first being the capture stage.
  logic signed [DW-1:0] a_edge   [N];
  logic signed [DW-1:0] b_edge   [N];
  logic                 a_edge_v [N];
  logic                 b_edge_v [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic signed [DW-1:0] a_sr [gi+1];
    logic signed [DW-1:0] b_sr [gi+1];
    logic                 a_sv [gi+1];
    logic                 b_sv [gi+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d <= gi; d++) begin
          a_sr[d] <= '0;
          b_sr[d] <= '0;
          a_sv[d] <= 1'b0;
          b_sv[d] <= 1'b0;
        end
      end else begin
        // Idle cycles inject zero operands with the tag cleared.
        a_sr[0] <= accept ? a_data[gi*DW +: DW] : '0;
        b_sr[0] <= accept ? b_data[gi*DW +: DW] : '0;
        a_sv[0] <= accept;
        b_sv[0] <= accept;
        for (int d = 1; d <= gi; d++) begin
          a_sr[d] <= a_sr[d-1];
          b_sr[d] <= b_sr[d-1];
          a_sv[d] <= a_sv[d-1];
          b_sv[d] <= b_sv[d-1];
        end
      end
    end

    assign a_edge[gi]   = a_sr[gi];
    assign b_edge[gi]   = b_sr[gi];
    assign a_edge_v[gi] = a_sv[gi];
    assign b_edge_v[gi] = b_sv[gi];
  end

  // PE grid: a moves right, b moves down; the last column/row has nowhere to forward to.
  logic signed [DW-1:0]    a_q   [N][N-1];
  logic                    va_q  [N][N-1];
  logic signed [DW-1:0]    b_q   [N-1][N];
  logic                    vb_q  [N-1][N];
  logic signed [ACC_W-1:0] acc   [N][N];
  logic signed [DW-1:0]    a_in  [N][N];
  logic signed [DW-1:0]    b_in  [N][N];
  logic                    va_in [N][N];
  logic                    vb_in [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0]  = a_edge[i];
      va_in[i][0] = a_edge_v[i];
      b_in[0][i]  = b_edge[i];
      vb_in[0][i] = b_edge_v[i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        a_in[i][j]  = a_q[i][j-1];
        va_in[i][j] = va_q[i][j-1];
        b_in[j][i]  = b_q[j-1][i];
        vb_in[j][i] = vb_q[j-1][i];
      end
    end
  end

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] acc_i,
                                                  input logic signed [DW-1:0]    a,
                                                  input logic signed [DW-1:0]    b);
    logic signed [2*DW-1:0] prod;
    prod = (2*DW)'(a) * (2*DW)'(b);
    // Two's-complement wrap at ACC_W bits, no saturation.
    return acc_i + ACC_W'(prod);
  endfunction

  // NOTE: the grid registers and accumulators are array storage, but all of them take the async reset so an aborted job leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
        end
        for (int j = 0; j < N-1; j++) begin
          a_q[i][j]  <= '0;
          va_q[i][j] <= 1'b0;
          b_q[j][i]  <= '0;
          vb_q[j][i] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          a_q[i][j]  <= a_in[i][j];
          va_q[i][j] <= va_in[i][j];
          b_q[j][i]  <= b_in[j][i];
          vb_q[j][i] <= vb_in[j][i];
        end
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (clear_acc) begin
            acc[i][j] <= '0;
          end else if (va_in[i][j] && vb_in[i][j]) begin
            acc[i][j] <= mac(acc[i][j], a_in[i][j], b_in[i][j]);
          end
        end
      end
    end
  end

  // The grid is quiet in DRAIN, so the selected accumulator row is stable under backpressure.
  // NOTE: out_row gets a default before the conditional write so no latch is inferred.
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*ACC_W +: ACC_W] = acc[out_row_idx][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: drives a 40-bit and a 32-bit accumulator instance in
// lockstep and checks every drained row against a plain sum-of-products model.
module tb_systolic_mm_engine;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int K_MAX = 256;
  localparam int ACC_W = 2*DW + $clog2(K_MAX);
  localparam int ACC_S = 32;
  localparam int KW    = $clog2(K_MAX+1);
  localparam int RW    = $clog2(N);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [N*DW-1:0]    a_data = '0;
  logic [N*DW-1:0]    b_data = '0;

  logic               in_ready, out_valid, busy, done;
  logic [N*ACC_W-1:0] out_row;
  logic [RW-1:0]      out_row_idx;
  logic               s_in_ready, s_out_valid, s_busy, s_done;
  logic [N*ACC_S-1:0] s_out_row;
  logic [RW-1:0]      s_out_row_idx;

  systolic_mm_engine #(.N(N), .DW(DW), .K_MAX(K_MAX), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  systolic_mm_engine #(.N(N), .DW(DW), .K_MAX(K_MAX), .ACC_W(ACC_S)) dut32 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row),
    .out_row_idx(s_out_row_idx), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  int     a_m [N][K_MAX];
  int     b_m [K_MAX][N];
  longint c_ref [N][N];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wrap(input longint v, input int w);
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model(input int k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
        c_ref[i][j] = s;
      end
    end
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = int'($urandom_range(0, 65535)) - 32768;
        b_m[kk][i] = int'($urandom_range(0, 65535)) - 32768;
      end
    end
  endtask

  task automatic fill_const(input int k, input int v);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = v;
        b_m[kk][i] = v;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/busy"},      {63'd0, busy},                      64'd0);
    check({tag, "/in_ready"},  {63'd0, in_ready},                  64'd0);
    check({tag, "/out_valid"}, {63'd0, out_valid},                 64'd0);
    check({tag, "/out_row"},   {63'd0, (out_row != '0)},           64'd0);
    check({tag, "/row_idx"},   64'(out_row_idx),                   64'd0);
    check({tag, "/done"},      {63'd0, done},                      64'd0);
    check({tag, "/s_busy"},    {63'd0, (s_busy | s_in_ready | s_out_valid | s_done)}, 64'd0);
    check({tag, "/s_out_row"}, {63'd0, (s_out_row != '0)},         64'd0);
  endtask

  // Called at a negedge with the engine idle; returns at the negedge showing the done pulse.
  task automatic run_job(input string name, input int k_req, input bit toggle,
                         input int stall, input bit glitch);
    int k;
    int nb;
    int guard;
    int lat;
    bit take;
    k = (k_req > K_MAX) ? K_MAX : k_req;
    model(k);
    start = 1'b1;
    k_len = KW'(k_req);
    @(negedge clk);
    start = 1'b0;
    check({name, "/busy_up"}, {63'd0, busy}, 64'd1);
    check({name, "/done_low"}, {63'd0, done}, 64'd0);

    nb = 0;
    guard = 0;
    while (nb < k && guard < 4*k + 20) begin
      in_valid = toggle ? (guard % 2 == 1) : 1'b1;
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = in_valid ? DW'(a_m[i][nb]) : DW'($urandom);
        b_data[i*DW +: DW] = in_valid ? DW'(b_m[nb][i]) : DW'($urandom);
      end
      if (glitch && guard == 1) begin
        start = 1'b1;
        k_len = KW'($urandom_range(1, K_MAX));
      end else begin
        start = 1'b0;
      end
      take = in_valid & in_ready;
      @(negedge clk);
      if (take) nb++;
      guard++;
    end
    start = 1'b0;
    check({name, "/beats"}, 64'(nb), 64'(k));
    check({name, "/in_ready_low"}, {63'd0, in_ready}, 64'd0);

    // Beats offered outside LOAD must be ignored.
    lat = 1;
    while (!out_valid && lat < 200) begin
      in_valid = 1'b1;
      a_data = {N{DW'($urandom)}};
      b_data = {N{DW'($urandom)}};
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({name, "/latency"}, 64'(lat), 64'(2*N));

    for (int r = 0; r < N; r++) begin
      for (int s = 0; s <= stall; s++) begin
        out_ready = (s == stall);
        start = (glitch && r == 1 && s == 0);
        check($sformatf("%s/valid_r%0d", name, r), {62'd0, out_valid, s_out_valid}, 64'd3);
        check($sformatf("%s/idx_r%0d", name, r), 64'({out_row_idx, s_out_row_idx}),
              64'({RW'(r), RW'(r)}));
        for (int j = 0; j < N; j++) begin
          check($sformatf("%s/c%0d%0d_w40", name, r, j), 64'(out_row[j*ACC_W +: ACC_W]),
                wrap(c_ref[r][j], ACC_W));
          check($sformatf("%s/c%0d%0d_w32", name, r, j), 64'(s_out_row[j*ACC_S +: ACC_S]),
                wrap(c_ref[r][j], ACC_S));
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    check({name, "/done"}, {62'd0, done, s_done}, 64'd3);
    check({name, "/busy_down"}, {62'd0, busy, s_busy}, 64'd0);
    check({name, "/valid_down"}, {62'd0, out_valid, s_out_valid}, 64'd0);
    check({name, "/row_zero"}, {62'd0, (out_row != '0), (s_out_row != '0)}, 64'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // A = identity, B[k][j] = 4k+j+1: rows of C are rows of B.
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = (i == kk) ? 1 : 0;
        b_m[kk][i] = 4*kk + i + 1;
      end
    end
    run_job("ident", 4, 1'b0, 0, 1'b0);
    run_job("ident_stall", 4, 1'b1, 3, 1'b1);

    fill_const(1, -32768);
    run_job("neg_k1", 1, 1'b0, 0, 1'b0);
    fill_const(4, -32768);
    run_job("neg_k4_wrap", 4, 1'b0, 1, 1'b0);

    run_job("k_zero", 0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      int kr;
      kr = int'($urandom_range(1, 12));
      fill_random(kr);
      run_job($sformatf("rand%0d", t), kr, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    fill_random(K_MAX);
    run_job("clamp", 300, 1'b0, 0, 1'b0);

    // Abort mid-LOAD with an asynchronous reset pulse.
    fill_random(6);
    start = 1'b1;
    k_len = KW'(6);
    @(negedge clk);
    start = 1'b0;
    for (int kk = 0; kk < 3; kk++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = DW'(a_m[i][kk]);
        b_data[i*DW +: DW] = DW'(b_m[kk][i]);
      end
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 check_quiet("abort");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    fill_random(5);
    run_job("after_abort", 5, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("final/done_pulse", {62'd0, done, s_done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply engine with a control FSM, input skewing and a row-serial result drain.
- Computes C = A x B for an NxK A matrix and a KxN B matrix, with K selectable per job.
- Successor to the fixed 4x4 PE grid. Adds generic size, valid/ready streaming, automatic skew, accumulator clear and backpressured readout.

Parameters:
- N, 4, array dimension (rows = columns = N), 2..16
- DW, 16, signed operand width
- K_MAX, 256, maximum inner dimension per job
- ACC_W, 2*DW+$clog2(K_MAX), signed accumulator and result width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner dimension K, sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat ready
- a_data  in  N*DW  lane i = A[i][k], signed
- b_data  in  N*DW  lane j = B[k][j], signed
- out_valid  out  1  result row valid
- out_ready  in  1  result row ready
- out_row  out  N*ACC_W  lane j = C[r][j]
- out_row_idx  out  $clog2(N)  row index r
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (rst=0, async): state=IDLE, all accumulators, skew and PE registers = 0. Outputs: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 latches k_len and clears all accumulators to 0 on that edge.
  - Next state is LOAD, or FLUSH if k_len=0.
- LOAD:
  - in_ready=1.
  - A beat is accepted on in_valid&in_ready; the beat counter increments per accepted beat.
  - Cycles with no accepted beat inject zero operands with the valid tag cleared (bubbles). Results are unaffected.
  - After beat k_len-1 is accepted, next state is FLUSH.
- Skew: a lane i is delayed i cycles before entering column 0; b lane j is delayed j cycles before entering row 0.
- PE(i,j):
  - Forwards a right and b down with 1-cycle registers, together with a valid tag.
  - acc += a*b on tagged-valid inputs, using a full-precision signed product.
  - The accumulator wraps modulo 2^ACC_W (two's complement); no saturation.
- FLUSH:
  - in_ready=0; lasts exactly 2N-1 cycles (counter).
  - Then DRAIN with r=0. out_valid rises 2N cycles after the edge that accepted the last beat.
- DRAIN:
  - out_valid=1; out_row holds accumulator row r; out_row_idx=r.
  - out_row and out_row_idx stay stable while out_valid&!out_ready.
  - On out_valid&out_ready: r increments. After r=N-1 is accepted, done=1 for one cycle and state goes to IDLE.
- start while busy=1 is ignored; k_len changes mid-job are ignored.
- k_len > K_MAX is clamped to K_MAX.
- in_valid outside LOAD is ignored; no beat is consumed.
- out_valid=0 outside DRAIN; out_row=0 outside DRAIN.
- Reset asserted mid-job aborts immediately to the reset state. No done pulse is produced.
- Back-to-back jobs: start is accepted in the cycle after done. Accumulators clear on that start.

Test Plan:
- N=4, K=4, A=identity, B[k][j]=4k+j+1, in_valid held 1:
  - rows out = B rows, e.g. row0 = {1,2,3,4}.
  - out_valid exactly 2N=8 cycles after the last beat; done pulse after row 3.
- Same job with in_valid toggled every other cycle and out_ready low for 3 cycles per row:
  - identical results; out_row stable while stalled; in_ready low after beat 3.
- Signed and wrap:
  - DW=16, K=1, A all -32768, B all -32768 -> every C = 2^30.
  - ACC_W forced to 32 with K=4 of the same values -> C = 2^32 mod 2^32 = 0.
- k_len=0 start -> no beats accepted; 4 rows of zeros drained; done pulses.
- start pulsed during LOAD and DRAIN -> ignored, job results unchanged.
- rst low for 1 cycle mid-LOAD -> busy=0 and all outputs 0 immediately. A following clean job returns correct results with no residue from the aborted job.
